mac_accumulator: RTL and testbench



---
 rtl/mac_accumulator.sv | 155 +++++++++++++++
 tb/tb_mac_accumulator.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// Accumulate stage of the 8x8 MAC datapath: sums a burst of unsigned
// products into a saturating accumulator and presents the result on valid/ready.
module mac_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf;

    logic [ACC_W-1:0]   r_out_acc;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_ovf;
    logic               r_out_valid;

    logic               w_ready;
    logic               w_accept;
    logic               w_take;
    logic [ACC_W:0]     w_prod_ext;
    logic [ACC_W:0]     w_sum;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_ovf_nxt;

    assign w_ready    = (r_state != DONE) && !clr;
    assign w_accept   = in_valid && w_ready;
    assign w_take     = r_out_valid && out_ready;

    assign w_prod_ext = {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
    assign w_sum      = {1'b0, r_acc} + w_prod_ext;
    assign w_cnt_inc  = (r_count == {CNT_W{1'b1}}) ? r_count
                                                   : r_count + CNT_W'(1);

    // Post-beat values; only committed when a beat is accepted.
    always_comb begin
        w_acc_nxt = r_acc;
        w_cnt_nxt = r_count;
        w_ovf_nxt = r_ovf;
        if (r_state == IDLE) begin
            w_acc_nxt = w_prod_ext[ACC_W-1:0];
            w_cnt_nxt = CNT_W'(1);
            w_ovf_nxt = 1'b0;
        end else begin
            w_cnt_nxt = w_cnt_inc;
            if (r_ovf || w_sum[ACC_W]) begin
                w_acc_nxt = {ACC_W{1'b1}};
                w_ovf_nxt = 1'b1;
            end else begin
                w_acc_nxt = w_sum[ACC_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = in_last ? DONE : ACC;
                end
            end
            ACC: begin
                if (w_accept && in_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (w_take) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (clr) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (clr) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= w_acc_nxt;
            r_count <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_acc   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (clr) begin
            r_out_acc   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept && in_last) begin
            r_out_acc   <= w_acc_nxt;
            r_out_count <= w_cnt_nxt;
            r_out_ovf   <= w_ovf_nxt;
            r_out_valid <= 1'b1;
        end else if (w_take) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: a bench-side model pushes
// expected results per burst, each scenario task pops and compares.
module tb_mac_accumulator;

    localparam int PROD_W = 16;
    localparam int ACC_W  = 24;
    localparam int CNT_W  = 8;

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } res_t;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_product;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    int checks;
    int errors;

    res_t             sb[$];
    logic [ACC_W-1:0] m_acc;
    logic [CNT_W-1:0] m_cnt;
    logic             m_ovf;
    logic             m_first;

    mac_accumulator #(
        .PROD_W(PROD_W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_product(in_product),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_beat(input logic [PROD_W-1:0] p, input logic last);
        logic [ACC_W:0] s;
        res_t r;
        if (m_first) begin
            m_acc = ACC_W'(p);
            m_cnt = 1;
            m_ovf = 1'b0;
            m_first = 1'b0;
        end else begin
            s = {1'b0, m_acc} + (ACC_W + 1)'(p);
            if (m_ovf || s > (ACC_W + 1)'(24'hFFFFFF)) begin
                m_acc = 24'hFFFFFF;
                m_ovf = 1'b1;
            end else begin
                m_acc = s[ACC_W-1:0];
            end
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 1;
        end
        if (last) begin
            r.acc = m_acc;
            r.cnt = m_cnt;
            r.ovf = m_ovf;
            sb.push_back(r);
            m_first = 1'b1;
        end
    endtask

    // Drives one beat, waits (bounded) for acceptance; returns #1 after the edge.
    task automatic send_beat(input logic [PROD_W-1:0] p, input logic last);
        int n;
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_beat timeout in_ready=%0b required=1", in_ready);
        end else begin
            model_beat(p, last);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_acc !== '0 ||
            out_count !== '0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%0b acc=%h cnt=%0d ovf=%0b required all 0",
                     out_valid, out_acc, out_count, out_ovf);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %0b required 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();
    endtask

    task automatic test_single();
        res_t e;
        send_beat(16'hFE01, 1'b1);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency out_valid=%0b required 1", out_valid);
        end
        e = sb.pop_front();
        checks++;
        if (out_acc !== e.acc || out_count !== e.cnt || out_ovf !== e.ovf) begin
            errors++;
            $display("FAIL single_result got %h/%0d/%0b required %h/%0d/%0b",
                     out_acc, out_count, out_ovf, e.acc, e.cnt, e.ovf);
        end
        checks++;
        if (out_acc !== 24'h00FE01) begin
            errors++;
            $display("FAIL single_const got %h required 00fe01", out_acc);
        end
        out_ready = 1'b1;
        idle_cycle();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_handshake out_valid=%0b required 0", out_valid);
        end
    endtask

    task automatic wait_and_take(input string name);
        res_t e;
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL %s timeout out_valid=0 required 1", name);
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected result acc=%h", name, out_acc);
        end else begin
            e = sb.pop_front();
            if (out_acc !== e.acc || out_count !== e.cnt || out_ovf !== e.ovf) begin
                errors++;
                $display("FAIL %s got %h/%0d/%0b required %h/%0d/%0b",
                         name, out_acc, out_count, out_ovf, e.acc, e.cnt, e.ovf);
            end
        end
        out_ready = 1'b1;
        idle_cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_burst();
        send_beat(16'd15, 1'b0);
        send_beat(16'd63, 1'b0);
        idle_cycle();
        send_beat(16'd65025, 1'b0);
        send_beat(16'd1, 1'b1);
        checks++;
        if (out_acc !== 24'h00FE50 || out_count !== 8'd4) begin
            errors++;
            $display("FAIL burst_const got %h/%0d required 00fe50/4",
                     out_acc, out_count);
        end
        wait_and_take("burst");
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 258; i++) send_beat(16'hFE01, 1'b0);
        checks++;
        if (m_acc !== 24'd16776450 || m_ovf !== 1'b0) begin
            errors++;
            $display("FAIL sat_model_258 got %0d/%0b required 16776450/0",
                     m_acc, m_ovf);
        end
        send_beat(16'hFE01, 1'b1);
        checks++;
        if (out_acc !== 24'hFFFFFF || out_ovf !== 1'b1 || out_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_const got %h/%0d/%0b required ffffff/255/1",
                     out_acc, out_count, out_ovf);
        end
        wait_and_take("saturate");
    endtask

    task automatic test_back_to_back();
        res_t e;
        logic [ACC_W-1:0] held;
        send_beat(16'h0010, 1'b1);
        held = out_acc;
        in_valid   = 1'b1;
        in_product = 16'h0010;
        in_last    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_acc !== held) begin
                errors++;
                $display("FAIL bp_hold cyc %0d rdy=%0b v=%0b acc=%h required 0/1/%h",
                         i, in_ready, out_valid, out_acc, held);
            end
        end
        e = sb.pop_front();
        checks++;
        if (out_acc !== e.acc || out_count !== e.cnt) begin
            errors++;
            $display("FAIL bp_first got %h/%0d required %h/%0d",
                     out_acc, out_count, e.acc, e.cnt);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle_cycle();
        out_ready = 1'b0;
        send_beat(16'h0010, 1'b1);
        checks++;
        if (out_acc !== 24'h000010 || out_count !== 8'd1) begin
            errors++;
            $display("FAIL bp_second_const got %h/%0d required 000010/1",
                     out_acc, out_count);
        end
        wait_and_take("bp_second");
        repeat (3) idle_cycle();
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL bp_no_dup out_valid=%0b pending=%0d required 0/0",
                     out_valid, sb.size());
        end
    endtask

    task automatic test_clr();
        send_beat(16'd100, 1'b0);
        send_beat(16'd200, 1'b0);
        clr        = 1'b1;
        in_valid   = 1'b1;
        in_product = 16'd300;
        in_last    = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_in_ready got %0b required 0", in_ready);
        end
        idle_cycle();
        clr      = 1'b0;
        in_valid = 1'b0;
        m_first  = 1'b1;
        send_beat(16'd7, 1'b1);
        checks++;
        if (out_acc !== 24'd7 || out_count !== 8'd1) begin
            errors++;
            $display("FAIL clr_const got %0d/%0d required 7/1", out_acc, out_count);
        end
        wait_and_take("clr");
    endtask

    task automatic test_async_reset();
        res_t e;
        send_beat(16'h1234, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_acc !== '0 ||
            out_count !== '0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL areset got v=%0b acc=%h cnt=%0d ovf=%0b required all 0",
                     out_valid, out_acc, out_count, out_ovf);
        end
        if (sb.size() != 0) e = sb.pop_front();
        m_first = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();
        send_beat(16'h0003, 1'b1);
        checks++;
        if (out_acc !== 24'd3) begin
            errors++;
            $display("FAIL areset_after got %0d required 3", out_acc);
        end
        wait_and_take("areset");
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        m_first    = 1'b1;
        m_acc      = '0;
        m_cnt      = '0;
        m_ovf      = 1'b0;
        clr        = 1'b0;
        in_valid   = 1'b0;
        in_product = '0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_saturate();
        test_back_to_back();
        test_clr();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
